// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the IF/LSU SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one multi-cycle single-port SRAM between instruction fetch and the
// LSU, returning registered read data and a pipeline-wide stall.
//
// state  | meaning
// IDLE   | no access in flight; grant LSU first, then IF
// ACCESS | SRAM outputs held, latency counter running down to zero
// RESP   | ack pulse for the granted requester; may chain straight to the other
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SRAM_LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,
  input  logic                i_lsu_req,
  input  logic                i_lsu_we,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_bmask,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_ack,
  output logic                o_sram_ce,
  output logic                o_sram_we,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]   o_sram_wdata,
  output logic [DATA_W/8-1:0] o_sram_bmask,
  input  logic [DATA_W-1:0]   i_sram_rdata,
  output logic                o_sram_stall
);

  localparam int BM_W  = DATA_W / 8;
  localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_LAT - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]       state;
  grant_e           gnt;
  grant_e           next_gnt;
  logic             do_grant;
  logic [CNT_W-1:0] cnt;
  logic             if_done;
  logic             lsu_done;
  logic             if_pend;
  logic             lsu_pend;

  assign if_pend  = i_if_req & ~if_done;
  assign lsu_pend = i_lsu_req & ~lsu_done;

  // Drops together with the last outstanding ack so the pipeline advances on that edge.
  assign o_sram_stall = ~i_rst & ((if_pend & ~o_if_ack) | (lsu_pend & ~o_lsu_ack));

  always_comb begin
    do_grant = 1'b0;
    next_gnt = GNT_IF;
    case (state)
      S_IDLE: begin
        if (lsu_pend) begin
          do_grant = 1'b1;
          next_gnt = GNT_LSU;
        end else if (if_pend) begin
          do_grant = 1'b1;
          next_gnt = GNT_IF;
        end
      end
      S_RESP: begin
        if (gnt == GNT_LSU && if_pend) begin
          do_grant = 1'b1;
          next_gnt = GNT_IF;
        end else if (gnt == GNT_IF && lsu_pend) begin
          do_grant = 1'b1;
          next_gnt = GNT_LSU;
        end
      end
      default: ;
    endcase
  end

  // Done flags keep a still-asserted, already-served request from re-issuing while frozen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
    end else if (o_sram_stall) begin
      if_done  <= if_done | o_if_ack;
      lsu_done <= lsu_done | o_lsu_ack;
    end else begin
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      gnt          <= GNT_IF;
      cnt          <= '0;
      o_sram_ce    <= 1'b0;
      o_sram_we    <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_bmask <= '0;
      o_if_ack     <= 1'b0;
      o_lsu_ack    <= 1'b0;
      o_if_rdata   <= '0;
      o_lsu_rdata  <= '0;
    end else begin
      o_if_ack  <= 1'b0;
      o_lsu_ack <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          o_sram_ce <= 1'b0;
          o_sram_we <= 1'b0;
          state     <= S_IDLE;
          if (do_grant) begin
            state     <= S_ACCESS;
            gnt       <= next_gnt;
            cnt       <= CNT_LOAD;
            o_sram_ce <= 1'b1;
            if (next_gnt == GNT_LSU) begin
              o_sram_we    <= i_lsu_we;
              o_sram_addr  <= i_lsu_addr;
              o_sram_wdata <= i_lsu_wdata;
              o_sram_bmask <= i_lsu_bmask;
            end else begin
              o_sram_we    <= 1'b0;
              o_sram_addr  <= i_if_addr;
              o_sram_wdata <= '0;
              o_sram_bmask <= {BM_W{1'b1}};
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            o_sram_ce <= 1'b0;
            o_sram_we <= 1'b0;
            if (gnt == GNT_LSU) begin
              o_lsu_ack <= 1'b1;
              if (!o_sram_we) o_lsu_rdata <= i_sram_rdata;
            end else begin
              o_if_ack   <= 1'b1;
              o_if_rdata <= i_sram_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter with a small behavioural SRAM.
module tb_sram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          lsu_req;
  logic          lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [BW-1:0] lsu_bmask;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_ack;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_bmask;
  logic [DW-1:0] sram_rdata;
  logic          stall;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_rdata   (if_rdata),
    .o_if_ack     (if_ack),
    .i_lsu_req    (lsu_req),
    .i_lsu_we     (lsu_we),
    .i_lsu_addr   (lsu_addr),
    .i_lsu_wdata  (lsu_wdata),
    .i_lsu_bmask  (lsu_bmask),
    .o_lsu_rdata  (lsu_rdata),
    .o_lsu_ack    (lsu_ack),
    .o_sram_ce    (sram_ce),
    .o_sram_we    (sram_we),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .o_sram_bmask (sram_bmask),
    .i_sram_rdata (sram_rdata),
    .o_sram_stall (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: fixed words plus one writable word at 0x200.
  logic [DW-1:0] word_200 = 32'h1122_3344;
  always @(posedge clk) begin
    if (sram_ce && sram_we && sram_addr == 18'h00200) begin
      for (int b = 0; b < BW; b++)
        if (sram_bmask[b]) word_200[b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end
  always_comb begin
    sram_rdata = 32'hBAD0_BAD0;
    case (sram_addr)
      18'h00010: sram_rdata = 32'h0000_0013;
      18'h00020: sram_rdata = 32'hA5A5_0001;
      18'h00200: sram_rdata = word_200;
      18'h00300: sram_rdata = 32'h1234_5678;
      default:   sram_rdata = 32'hBAD0_BAD0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t lsu_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops an expectation whenever an ack is presented.
  always @(negedge clk) begin
    if (sram_ce) ce_cnt++;
    if (if_ack) begin
      if (if_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL if_ack_unexpected: ack at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = if_q.pop_front();
        check("if_rdata", if_rdata, e.data);
        check("if_ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (lsu_ack) begin
      if (lsu_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lsu_ack_unexpected: ack at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = lsu_q.pop_front();
        check("lsu_rdata", lsu_rdata, e.data);
        check("lsu_ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run time exceeded, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0;
  int base;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_bmask = '0;
    repeat (3) tick();

    // Reset state, with a request present to show stall is forced low
    if_req = 1'b1;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_ce", {31'b0, sram_ce}, 32'd0);
    check("rst_we", {31'b0, sram_we}, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_bmask", 32'(sram_bmask), 32'd0);
    check("rst_acks", {30'b0, if_ack, lsu_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // IF-only read
    t0 = cyc;
    if_req = 1'b1; if_addr = 18'h00010;
    if_q.push_back('{32'h0000_0013, t0 + 3});
    #1 check("t1_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    check("t1_c1_ce", {31'b0, sram_ce}, 32'd1);
    check("t1_c1_addr", 32'(sram_addr), 32'h10);
    check("t1_c1_we_bmask", {27'b0, sram_we, sram_bmask}, 32'h0F);
    check("t1_c1_stall", {31'b0, stall}, 32'd1);
    tick();
    check("t1_c2_ce", {31'b0, sram_ce}, 32'd1);
    check("t1_c2_stall", {31'b0, stall}, 32'd1);
    tick();
    check("t1_c3_ce", {31'b0, sram_ce}, 32'd0);
    check("t1_c3_stall", {31'b0, stall}, 32'd0);
    tick();
    if_req = 1'b0;
    tick();
    check("t1_idle_ce", {31'b0, sram_ce}, 32'd0);

    // IF read and LSU partial write together: LSU first
    t0 = cyc;
    if_req = 1'b1; if_addr = 18'h00020;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 18'h00200;
    lsu_wdata = 32'hDEAD_BEEF; lsu_bmask = 4'b0011;
    lsu_q.push_back('{32'h0000_0000, t0 + 3});
    if_q.push_back('{32'hA5A5_0001, t0 + 6});
    #1 check("t2_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    check("t2_c1_ce_we", {30'b0, sram_ce, sram_we}, 32'd3);
    check("t2_c1_addr", 32'(sram_addr), 32'h200);
    check("t2_c1_wdata", sram_wdata, 32'hDEAD_BEEF);
    check("t2_c1_bmask", 32'(sram_bmask), 32'h3);
    tick();
    check("t2_c2_ce_we", {30'b0, sram_ce, sram_we}, 32'd3);
    tick();
    check("t2_c3_ce_we", {30'b0, sram_ce, sram_we}, 32'd0);
    check("t2_c3_stall", {31'b0, stall}, 32'd1);
    tick();
    check("t2_c4_ce_we", {30'b0, sram_ce, sram_we}, 32'd2);
    check("t2_c4_addr", 32'(sram_addr), 32'h20);
    check("t2_c4_bmask", 32'(sram_bmask), 32'hF);
    tick();
    check("t2_c5_ce", {31'b0, sram_ce}, 32'd1);
    tick();
    check("t2_c6_stall", {31'b0, stall}, 32'd0);
    tick();
    if_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
    tick();

    // Both reads held after their acks: one access each per stall window
    t0 = cyc;
    base = ce_cnt;
    if_req = 1'b1; if_addr = 18'h00010;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 18'h00200;
    lsu_q.push_back('{32'h1122_BEEF, t0 + 3});
    if_q.push_back('{32'h0000_0013, t0 + 6});
    repeat (3) tick();
    check("t3_c3_stall", {31'b0, stall}, 32'd1);
    repeat (3) tick();
    check("t3_c6_stall", {31'b0, stall}, 32'd0);
    tick();
    if_req = 1'b0; lsu_req = 1'b0;
    check("t3_c7_ce", {31'b0, sram_ce}, 32'd0);
    check("t3_ce_cycles", 32'(ce_cnt - base), 32'd4);
    tick();
    check("t3_c8_ce", {31'b0, sram_ce}, 32'd0);

    // LSU-only read to load a known value
    t0 = cyc;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 18'h00300;
    lsu_q.push_back('{32'h1234_5678, t0 + 3});
    repeat (3) tick();
    check("t5_c3_stall", {31'b0, stall}, 32'd0);
    tick();
    lsu_req = 1'b0;
    tick();

    // Idle: nothing moves, read data holds
    for (int i = 0; i < 4; i++) begin
      check("idle_ce", {31'b0, sram_ce}, 32'd0);
      check("idle_stall", {31'b0, stall}, 32'd0);
      check("idle_lsu_rdata", lsu_rdata, 32'h1234_5678);
      tick();
    end

    // Reset during the first access cycle abandons it; held request restarts
    t0 = cyc;
    if_req = 1'b1; if_addr = 18'h00010;
    tick();
    rst = 1'b1;
    #1 check("t4_c1_stall_rst", {31'b0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t4_c2_ce", {31'b0, sram_ce}, 32'd0);
    check("t4_c2_ack", {31'b0, if_ack}, 32'd0);
    check("t4_c2_stall", {31'b0, stall}, 32'd1);
    check("t4_c2_lsu_rdata", lsu_rdata, 32'd0);
    if_q.push_back('{32'h0000_0013, t0 + 5});
    tick();
    check("t4_c3_ce", {31'b0, sram_ce}, 32'd1);
    repeat (2) tick();
    check("t4_c5_stall", {31'b0, stall}, 32'd0);
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("lsu_q_drained", 32'(lsu_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port, multi-cycle SRAM between instruction fetch (IF) and the load/store unit (LSU).
- Sequences each access through a small FSM and returns registered read data.
- Generates the pipeline-wide o_sram_stall that the hazard unit uses to freeze PC and all pipeline registers.
- Per stall window, each pending requester is served exactly once, LSU first.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 32, data width; byte-mask width is DATA_W/8.
- SRAM_LAT, 2, cycles the SRAM needs per access (>=1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_if_req  in  1  IF read request (level)
- i_if_addr  in  ADDR_W  IF address
- o_if_rdata  out  DATA_W  IF read data (registered)
- o_if_ack  out  1  IF completion pulse
- i_lsu_req  in  1  LSU request (level)
- i_lsu_we  in  1  LSU write enable
- i_lsu_addr  in  ADDR_W  LSU address
- i_lsu_wdata  in  DATA_W  LSU write data
- i_lsu_bmask  in  DATA_W/8  LSU byte mask
- o_lsu_rdata  out  DATA_W  LSU read data (registered)
- o_lsu_ack  out  1  LSU completion pulse
- o_sram_ce  out  1  SRAM chip enable
- o_sram_we  out  1  SRAM write enable
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_wdata  out  DATA_W  SRAM write data
- o_sram_bmask  out  DATA_W/8  SRAM byte mask
- i_sram_rdata  in  DATA_W  SRAM read data
- o_sram_stall  out  1  freeze pipeline

Behaviour:
- Clocking and reset: one clock, i_clk; i_rst is synchronous and active-high.
- Reset values: state IDLE; o_sram_ce/we/addr/wdata/bmask = 0; both acks 0; both rdata registers 0; done flags 0; o_sram_stall forced 0 while i_rst is high.
- Reset mid-access abandons the access with no ack.
- Pending definition: if_pend = i_if_req & ~if_done; lsu_pend = i_lsu_req & ~lsu_done.
- Stall (combinational): o_sram_stall = (if_pend & ~o_if_ack) | (lsu_pend & ~o_lsu_ack).
  - Drops in the same cycle as the last required ack, so the pipeline advances on that edge.
- Done flags: next = o_sram_stall ? (done | ack) : 0. This prevents re-issue while frozen requests stay asserted.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If lsu_pend, grant LSU; else if if_pend, grant IF; else stay.
  - On grant: register SRAM outputs from the granted requester, load cnt = SRAM_LAT-1, go to ACCESS.
  - IF accesses drive we=0 and bmask all-ones.
- ACCESS:
  - ce=1, we per grant, outputs held stable.
  - cnt decrements each cycle; when cnt==0, capture i_sram_rdata into the granted rdata register (reads only) and go to RESP.
- RESP:
  - Pulse the granted ack for 1 cycle; ce=0, we=0.
  - If the other requester is pending, grant it directly (load outputs, cnt, go to ACCESS); else go to IDLE.
- Latency: a request seen in IDLE at cycle 0 acks at cycle SRAM_LAT+1. A back-to-back second access acks at cycle 2*SRAM_LAT+2.
- Writes: o_lsu_rdata is unchanged; the ack timing is identical to a read.
- Both rdata registers hold their value until the next read capture for that requester.
- A request deasserted mid-access still completes and acks; requesters must hold address/data until ack.
- Counter width: $clog2(SRAM_LAT+1). For SRAM_LAT=1, ACCESS lasts exactly 1 cycle.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - grant enum {GNT_IF, GNT_LSU}
  - default ADDR_W/DATA_W localparams
- No sub-module; the latency counter stays inline.

Test Plan (SRAM_LAT=2):
- IF-only read, addr 0x00010, SRAM returns 0x00000013 -> ce high cycles 1-2; o_if_ack and o_if_rdata=0x00000013 at cycle 3; stall high cycles 0-2, low cycle 3.
- IF read plus LSU write (addr 0x00200, wdata 0xDEADBEEF, bmask 4'b0011) both at cycle 0 -> LSU write first; we=1 only cycles 1-2; lsu_ack cycle 3 with stall still high; IF access cycles 4-5; if_ack cycle 6 with stall low.
- LSU read while the frozen requests stay asserted after their acks -> exactly one access per requester per stall window; no second ce burst.
- i_rst asserted in cycle 1 of an access -> next cycle IDLE, ce=0, no ack, flags 0; a held request restarts after reset and acks SRAM_LAT+1 cycles later.
- Idle cycles with no requests -> ce=0 and stall=0; o_lsu_rdata keeps its prior value 0x12345678.
